// File: rtl/uart_tx.sv
// uart_tx: 8N1 parallel-to-serial UART transmitter, LSB first.
// Accepts a byte on a one-cycle start strobe when idle and drives txd from a
// flop so the line never glitches. Bit period is CLKS_PER_BIT clocks.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | line high, waiting for tx_start
// ST_START | driving the start bit (low) for one bit period
// ST_DATA  | shifting out data bits 0..7, LSB first
// ST_STOP  | driving the stop bit (high); tx_done pulses when it ends
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    localparam logic [15:0] CNT_TOP = 16'(CLKS_PER_BIT);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  idx_q;
    logic [7:0]  sh_q;
    logic        txd_q;
    logic        busy_q;
    logic        done_q;
    logic        bit_tick;

    // A bit ends on the cycle the counter reaches its top value.
    assign bit_tick = (cnt_q == CNT_TOP);

    // Frame sequencer: state, bit timing, payload shift and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd1;
            idx_q   <= 3'd0;
            sh_q    <= 8'h00;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != ST_IDLE) begin
                cnt_q <= bit_tick ? 16'd1 : cnt_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    txd_q  <= 1'b1;
                    busy_q <= 1'b0;
                    cnt_q  <= 16'd1;
                    if (tx_start) begin
                        sh_q    <= tx_data;
                        txd_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_tick) begin
                        txd_q   <= sh_q[0];
                        sh_q    <= sh_q >> 1;
                        idx_q   <= 3'd0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        if (idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= ST_STOP;
                        end else begin
                            txd_q <= sh_q[0];
                            sh_q  <= sh_q >> 1;
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable with a full 2-bit enum; recover to a quiet line.
                    state_q <= ST_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                    cnt_q   <= 16'd1;
                end
            endcase
        end
    end

    assign txd     = txd_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed, table-driven bench for uart_tx at CLKS_PER_BIT=4,
// plus one frame on a default-rate instance decoded by mid-bit sampling.
module tb_uart_tx;

    logic       clk;
    logic       n_rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       txd;
    logic       tx_busy;
    logic       tx_done;

    logic       d_start;
    logic [7:0] d_data;
    logic       d_txd;
    logic       d_busy;
    logic       d_done;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx #(.CLKS_PER_BIT(4)) u_dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .txd      (txd),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    uart_tx u_def (
        .clk      (clk),
        .n_rst    (n_rst),
        .tx_start (d_start),
        .tx_data  (d_data),
        .txd      (d_txd),
        .tx_busy  (d_busy),
        .tx_done  (d_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t vecs [4];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Checks one frame starting just after its accepting edge; optionally pokes a
    // start strobe mid-frame, or returns early at cycle stop_at.
    task automatic check_body(input logic [9:0] exp, input string nm, input bit poke, input int stop_at);
        for (int c = 0; c < 40; c++) begin
            if (c == stop_at) return;
            chk({nm, "_txd"}, 32'(txd), 32'(exp[c / 4]));
            chk({nm, "_busy"}, 32'(tx_busy), 32'd1);
            chk({nm, "_done"}, 32'(tx_done), 32'd0);
            if (poke && c == 15) begin
                tx_start = 1'b1;
                tx_data  = 8'hFF;
            end else if (poke && c == 16) begin
                tx_start = 1'b0;
            end
            step();
        end
        chk({nm, "_done_end"}, 32'(tx_done), 32'd1);
        chk({nm, "_busy_end"}, 32'(tx_busy), 32'd0);
        chk({nm, "_txd_end"}, 32'(txd), 32'd1);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [9:0] exp, input string nm);
        tx_data  = d;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        tx_data  = ~d;
        check_body(exp, nm, 1'b0, 40);
        step();
        chk({nm, "_done_clr"}, 32'(tx_done), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        int         wait_cnt;

        vecs[0] = '{data: 8'hA5, frame: 10'b1_1010_0101_0};
        vecs[1] = '{data: 8'hFF, frame: 10'b1_1111_1111_0};
        vecs[2] = '{data: 8'h55, frame: 10'b1_0101_0101_0};
        vecs[3] = '{data: 8'h3C, frame: 10'b1_0011_1100_0};

        n_rst    = 1'b0;
        tx_start = 1'b1;
        tx_data  = 8'hA5;
        d_start  = 1'b0;
        d_data   = 8'h00;

        // Reset held with tx_start high: line stays idle.
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_txd", 32'(txd), 32'd1);
            chk("rst_busy", 32'(tx_busy), 32'd0);
            chk("rst_done", 32'(tx_done), 32'd0);
        end
        tx_start = 1'b0;
        n_rst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_txd", 32'(txd), 32'd1);
            chk("post_rst_busy", 32'(tx_busy), 32'd0);
        end

        // Table-driven single frames.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].data, vecs[v].frame, $sformatf("vec%0d", v));
            step();
        end

        // Busy ignore: 0x3C frame with a 0xFF strobe at cycle 15.
        tx_data  = 8'h3C;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        check_body(10'b1_0011_1100_0, "busy_ign", 1'b1, 40);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("busy_ign_idle_txd", 32'(txd), 32'd1);
            chk("busy_ign_idle_busy", 32'(tx_busy), 32'd0);
            chk("busy_ign_idle_done", 32'(tx_done), 32'd0);
        end

        // Back-to-back with tx_start held high: 0x01 then 0x80, 41 cycles apart.
        tx_data  = 8'h01;
        tx_start = 1'b1;
        step();
        tx_data = 8'h80;
        check_body(10'b1_0000_0001_0, "b2b_a", 1'b0, 40);
        step();
        tx_start = 1'b0;
        check_body(10'b1_1000_0000_0, "b2b_b", 1'b0, 40);
        step();
        chk("b2b_done_clr", 32'(tx_done), 32'd0);
        step();
        chk("b2b_no_third", 32'(tx_busy), 32'd0);

        // Reset during data bit 3 of 0x00, then a clean 0x55 frame.
        tx_data  = 8'h00;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        check_body(10'b1_0000_0000_0, "midrst", 1'b0, 17);
        n_rst = 1'b0;
        #1;
        chk("midrst_txd_async", 32'(txd), 32'd1);
        chk("midrst_busy_async", 32'(tx_busy), 32'd0);
        chk("midrst_done_async", 32'(tx_done), 32'd0);
        step();
        step();
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_idle_txd", 32'(txd), 32'd1);
            chk("midrst_idle_busy", 32'(tx_busy), 32'd0);
        end
        send_frame(8'h55, 10'b1_0101_0101_0, "after_rst");

        // Default-rate instance: decode 0xA5 by sampling mid-bit.
        d_data  = 8'hA5;
        d_start = 1'b1;
        step();
        d_start = 1'b0;
        d_data  = 8'h00;
        bits    = '0;
        repeat (2604) step();
        for (int b = 0; b < 10; b++) begin
            bits[b] = d_txd;
            if (b < 9) repeat (5208) step();
        end
        chk("def_start_bit", 32'(bits[0]), 32'd0);
        chk("def_byte", 32'(bits[8:1]), 32'hA5);
        chk("def_stop_bit", 32'(bits[9]), 32'd1);
        chk("def_busy_in_stop", 32'(d_busy), 32'd1);
        wait_cnt = 0;
        while (!d_done && wait_cnt < 3000) begin
            step();
            wait_cnt++;
        end
        chk("def_done_latency", 32'(wait_cnt), 32'd2604);
        chk("def_busy_end", 32'(d_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
